// File: rtl/usb_cmd_parser.sv
// Command decoder between the FT232H bridge FIFOs and the scanner register bus.
// Frames 5-byte host commands, performs one register access and returns a 5-byte response.
module usb_cmd_parser #(
  parameter int unsigned RX_FIFO_L_BITS = 9,
  parameter int unsigned TX_FIFO_L_BITS = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk_i,
  input  logic                      nrst,
  output logic                      rxf_rdreq_o,
  input  logic [7:0]                rxf_rddata_i,
  input  logic [RX_FIFO_L_BITS-1:0] rxf_rdusedw_i,
  output logic                      txe_wrreq_o,
  output logic [7:0]                txe_wrdata_o,
  input  logic [TX_FIFO_L_BITS-1:0] txe_wrusedw_i,
  input  logic                      txe_wrfull_i,
  output logic                      reg_wr_o,
  output logic                      reg_rd_o,
  output logic [7:0]                reg_addr_o,
  output logic [7:0]                reg_wdata_o,
  input  logic [7:0]                reg_rdata_i,
  output logic [7:0]                err_cnt_o,
  output logic                      busy_o
);

  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TX_DEPTH = 1 << TX_FIFO_L_BITS;
  localparam logic [TX_FIFO_L_BITS-1:0] TX_LVL_MAX = TX_FIFO_L_BITS'(TX_DEPTH - 6);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_SYNC  = 8'hA5;
  localparam logic [7:0] RESP_SYNC = 8'h5A;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BADCHK = 8'h01;
  localparam logic [7:0] ST_BADCMD = 8'h02;

  typedef enum logic [3:0] {
    S_SYNC, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RDWAIT, S_RESP_WAIT, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            rdreq_q, rdreq_d;
  logic            byte_vld_q;
  logic [7:0]      cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
  logic            chk_ok_q, chk_ok_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
  logic [7:0]      reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
  logic [7:0]      status_q, status_d, rdata_q, rdata_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      txd_q, txd_d;
  logic [7:0]      err_q, err_d;
  logic            busy_q, busy_d;
  logic            in_fetch, got_byte, err_inc;
  logic [7:0]      resp_nxt;

  // Next-state, byte capture, register access and response sequencing
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    chk_ok_d    = chk_ok_q;
    to_cnt_d    = '0;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
    idx_d       = idx_q;
    txd_d       = txd_q;
    err_inc     = 1'b0;
    in_fetch    = state_q inside {S_SYNC, S_CMD, S_ADDR, S_DATA, S_CHK};
    got_byte    = in_fetch && byte_vld_q;

    case (idx_q)
      3'd0:    resp_nxt = status_q;
      3'd1:    resp_nxt = addr_q;
      3'd2:    resp_nxt = rdata_q;
      default: resp_nxt = status_q ^ addr_q ^ rdata_q;
    endcase

    case (state_q)
      S_SYNC: if (got_byte && rxf_rddata_i == CMD_SYNC) state_d = S_CMD;
      S_CMD:  if (got_byte) begin cmd_d  = rxf_rddata_i; state_d = S_ADDR; end
      S_ADDR: if (got_byte) begin addr_d = rxf_rddata_i; state_d = S_DATA; end
      S_DATA: if (got_byte) begin data_d = rxf_rddata_i; state_d = S_CHK;  end
      S_CHK: begin
        if (got_byte) begin
          chk_ok_d = (rxf_rddata_i == (cmd_q ^ addr_q ^ data_q));
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        reg_addr_d  = addr_q;
        reg_wdata_d = data_q;
        rdata_d     = 8'h00;
        state_d     = S_RESP_WAIT;
        if (!chk_ok_q) begin
          status_d = ST_BADCHK;
          err_inc  = 1'b1;
        end else if (cmd_q != CMD_WR && cmd_q != CMD_RD) begin
          status_d = ST_BADCMD;
          err_inc  = 1'b1;
        end else if (cmd_q == CMD_WR) begin
          status_d = ST_OK;
          rdata_d  = data_q;
          reg_wr_d = 1'b1;
        end else begin
          status_d = ST_OK;
          reg_rd_d = 1'b1;
          state_d  = S_RDWAIT;
        end
      end
      // Read data is valid the cycle after the strobe, i.e. once reg_rd_q has dropped
      S_RDWAIT: if (!reg_rd_q) begin rdata_d = reg_rdata_i; state_d = S_RESP_WAIT; end
      S_RESP_WAIT: begin
        idx_d = 3'd0;
        txd_d = RESP_SYNC;
        if (txe_wrusedw_i <= TX_LVL_MAX && !txe_wrfull_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (!txe_wrfull_i) begin
          if (idx_q == 3'd4) begin
            state_d = S_SYNC;
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = resp_nxt;
          end
        end
      end
      default: state_d = S_SYNC;
    endcase

    // Inter-byte timeout inside a partial packet
    if ((state_q inside {S_CMD, S_ADDR, S_DATA, S_CHK}) && !got_byte) begin
      if (to_cnt_q == TO_LAST) begin
        state_d = S_SYNC;
        err_inc = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    err_d   = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    // Only fetch when the next state still consumes bytes, so no byte lands in S_EXEC
    rdreq_d = (state_d inside {S_SYNC, S_CMD, S_ADDR, S_DATA, S_CHK}) &&
              (rxf_rdusedw_i != '0) && !rdreq_q;
    busy_d  = (state_d != S_SYNC);
  end

  always_ff @(posedge clk_i) begin
    if (!nrst) begin
      state_q     <= S_SYNC;
      rdreq_q     <= 1'b0;
      byte_vld_q  <= 1'b0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      chk_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      status_q    <= '0;
      rdata_q     <= '0;
      idx_q       <= '0;
      txd_q       <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdreq_q     <= rdreq_d;
      byte_vld_q  <= rdreq_q;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      chk_ok_q    <= chk_ok_d;
      to_cnt_q    <= to_cnt_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      idx_q       <= idx_d;
      txd_q       <= txd_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // TX write must follow the same-cycle full flag, hence decoded from state and input
  assign txe_wrreq_o  = (state_q == S_RESP) && !txe_wrfull_i;
  assign txe_wrdata_o = txd_q;
  assign rxf_rdreq_o  = rdreq_q;
  assign reg_wr_o     = reg_wr_q;
  assign reg_rd_o     = reg_rd_q;
  assign reg_addr_o   = reg_addr_q;
  assign reg_wdata_o  = reg_wdata_q;
  assign err_cnt_o    = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Bench for usb_cmd_parser: bridge FIFO and register-file models around the DUT,
// directed packets plus randomized packets checked against a packet-level reference model.
module tb_usb_cmd_parser;

  localparam int unsigned RXB      = 9;
  localparam int unsigned TXB      = 9;
  localparam int unsigned TO_CYC   = 100;
  localparam int unsigned TX_DEPTH = 1 << TXB;

  logic           clk_i = 1'b0;
  logic           nrst;
  logic           rxf_rdreq_o;
  logic [7:0]     rxf_rddata_i;
  logic [RXB-1:0] rxf_rdusedw_i;
  logic           txe_wrreq_o;
  logic [7:0]     txe_wrdata_o;
  logic [TXB-1:0] txe_wrusedw_i;
  logic           txe_wrfull_i;
  logic           reg_wr_o;
  logic           reg_rd_o;
  logic [7:0]     reg_addr_o;
  logic [7:0]     reg_wdata_o;
  logic [7:0]     reg_rdata_i;
  logic [7:0]     err_cnt_o;
  logic           busy_o;

  always #5 clk_i = ~clk_i;

  usb_cmd_parser #(
    .RX_FIFO_L_BITS(RXB),
    .TX_FIFO_L_BITS(TXB),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk_i        (clk_i),
    .nrst         (nrst),
    .rxf_rdreq_o  (rxf_rdreq_o),
    .rxf_rddata_i (rxf_rddata_i),
    .rxf_rdusedw_i(rxf_rdusedw_i),
    .txe_wrreq_o  (txe_wrreq_o),
    .txe_wrdata_o (txe_wrdata_o),
    .txe_wrusedw_i(txe_wrusedw_i),
    .txe_wrfull_i (txe_wrfull_i),
    .reg_wr_o     (reg_wr_o),
    .reg_rd_o     (reg_rd_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_rdata_i  (reg_rdata_i),
    .err_cnt_o    (err_cnt_o),
    .busy_o       (busy_o)
  );

  // RX bridge FIFO: non-showahead, host side fills rx_mem from the main sequence
  logic [7:0]  rx_mem [0:2047];
  int unsigned rx_wp = 0;
  int unsigned rx_rp = 0;
  assign rxf_rdusedw_i = RXB'(rx_wp - rx_rp);

  always @(posedge clk_i) begin
    if (rxf_rdreq_o === 1'b1) begin
      rxf_rddata_i <= rx_mem[rx_rp[10:0]];
      rx_rp        <= rx_rp + 1;
    end
  end

  // Register file device with one-cycle read latency
  bit [7:0] dev_mem [0:255];
  always @(posedge clk_i) begin
    if (reg_wr_o === 1'b1) dev_mem[reg_addr_o] <= reg_wdata_o;
    if (reg_rd_o === 1'b1) reg_rdata_i <= dev_mem[reg_addr_o];
  end

  // TX FIFO capture and strobe monitor, sampled mid-cycle
  logic [7:0]  tx_mem [0:2047];
  int unsigned tx_wp = 0;
  int unsigned wr_cnt = 0, rd_cnt = 0, full_viol = 0;
  logic [7:0]  wr_addr_seen, wr_data_seen, rd_addr_seen;

  always @(negedge clk_i) begin
    if (txe_wrreq_o === 1'b1) begin
      tx_mem[tx_wp[10:0]] <= txe_wrdata_o;
      tx_wp               <= tx_wp + 1;
      if (txe_wrfull_i === 1'b1) full_viol <= full_viol + 1;
    end
    if (reg_wr_o === 1'b1) begin
      wr_cnt       <= wr_cnt + 1;
      wr_addr_seen <= reg_addr_o;
      wr_data_seen <= reg_wdata_o;
    end
    if (reg_rd_o === 1'b1) begin
      rd_cnt       <= rd_cnt + 1;
      rd_addr_seen <= reg_addr_o;
    end
  end

  int          checks = 0;
  int          errors = 0;
  bit [7:0]    shadow [0:255];
  logic [7:0]  exp_resp [0:4];
  logic [7:0]  exp_addr, exp_data;
  int unsigned exp_wr, exp_rd, exp_err;
  int unsigned tx0, wr0, rd0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wp[10:0]] = b;
    rx_wp = rx_wp + 1;
  endtask

  // Packet-level reference: outcome, response bytes and error count from the protocol rules
  task automatic model(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] k);
    logic [7:0] st, rdv;
    exp_wr = 0;
    exp_rd = 0;
    if (k != (c ^ a ^ d)) begin
      st = 8'h01; rdv = 8'h00;
    end else if (c != 8'h01 && c != 8'h02) begin
      st = 8'h02; rdv = 8'h00;
    end else if (c == 8'h01) begin
      st = 8'h00; rdv = d; shadow[a] = d; exp_wr = 1;
    end else begin
      st = 8'h00; rdv = shadow[a]; exp_rd = 1;
    end
    if (st != 8'h00 && exp_err < 255) exp_err++;
    exp_resp[0] = 8'h5A;
    exp_resp[1] = st;
    exp_resp[2] = a;
    exp_resp[3] = rdv;
    exp_resp[4] = st ^ a ^ rdv;
    exp_addr = a;
    exp_data = d;
  endtask

  task automatic start_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] k, input int njunk);
    for (int j = 0; j < njunk; j++) begin
      logic [7:0] jb;
      do jb = 8'($urandom); while (jb == 8'hA5);
      push(jb);
    end
    model(c, a, d, k);
    tx0 = tx_wp;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    push(8'hA5); push(c); push(a); push(d); push(k);
  endtask

  task automatic finish_pkt(input string tag, input bit rand_bp);
    int n = 0;
    while ((tx_wp - tx0) < 5 && n < 600) begin
      if (rand_bp) txe_wrfull_i = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    txe_wrfull_i = 1'b0;
    repeat (4) tick();
    check({tag, "_txcount"}, tx_wp - tx0, 5);
    check({tag, "_busy"}, busy_o, 0);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_resp%0d", tag, i), tx_mem[(tx0 + i) % 2048], exp_resp[i]);
    check({tag, "_wr_pulses"}, wr_cnt - wr0, exp_wr);
    check({tag, "_rd_pulses"}, rd_cnt - rd0, exp_rd);
    if (exp_wr != 0) begin
      check({tag, "_wr_addr"}, wr_addr_seen, exp_addr);
      check({tag, "_wr_data"}, wr_data_seen, exp_data);
    end
    if (exp_rd != 0) check({tag, "_rd_addr"}, rd_addr_seen, exp_addr);
    check({tag, "_err"}, err_cnt_o, exp_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdreq"}, rxf_rdreq_o, 0);
    check({tag, "_wrreq"}, txe_wrreq_o, 0);
    check({tag, "_regwr"}, reg_wr_o, 0);
    check({tag, "_regrd"}, reg_rd_o, 0);
    check({tag, "_addr"}, reg_addr_o, 0);
    check({tag, "_wdata"}, reg_wdata_o, 0);
    check({tag, "_txdata"}, txe_wrdata_o, 0);
    check({tag, "_err"}, err_cnt_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    int n;
    logic [7:0] c, a, d, k;
    nrst          = 1'b0;
    txe_wrusedw_i = '0;
    txe_wrfull_i  = 1'b0;
    exp_err       = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    nrst = 1'b1;
    tick();

    start_pkt(8'h01, 8'h10, 8'h3C, 8'h2D, 0);
    finish_pkt("write", 1'b0);
    start_pkt(8'h01, 8'h20, 8'h77, 8'h56, 0);
    finish_pkt("write2", 1'b0);
    start_pkt(8'h02, 8'h20, 8'h00, 8'h22, 0);
    finish_pkt("read", 1'b0);
    start_pkt(8'h01, 8'h10, 8'h3C, 8'h00, 0);
    finish_pkt("badchk", 1'b0);
    check("badchk_err_is_1", err_cnt_o, 1);
    start_pkt(8'h07, 8'h10, 8'h00, 8'h17, 0);
    finish_pkt("badcmd", 1'b0);
    check("badcmd_err_is_2", err_cnt_o, 2);

    push(8'h00); push(8'hFF); push(8'h5A);
    start_pkt(8'h01, 8'h33, 8'hC4, 8'h01 ^ 8'h33 ^ 8'hC4, 0);
    finish_pkt("resync", 1'b0);

    // Partial packet then silence
    tx0 = tx_wp;
    push(8'hA5); push(8'h01);
    n = 0;
    while (rx_rp != rx_wp && n < 50) begin tick(); n++; end
    repeat (TO_CYC / 2) tick();
    check("timeout_busy_before", busy_o, 1);
    repeat (TO_CYC) tick();
    check("timeout_busy_after", busy_o, 0);
    exp_err++;
    check("timeout_err", err_cnt_o, exp_err);
    check("timeout_no_tx", tx_wp - tx0, 0);

    // TX fill level too high, then exactly at the allowed limit
    txe_wrusedw_i = TXB'(TX_DEPTH - 3);
    start_pkt(8'h02, 8'h10, 8'h00, 8'h12, 0);
    repeat (60) tick();
    check("hold_no_tx", tx_wp - tx0, 0);
    check("hold_busy", busy_o, 1);
    txe_wrusedw_i = TXB'(TX_DEPTH - 6);
    finish_pkt("hold", 1'b0);
    txe_wrusedw_i = '0;

    // TX full asserted right after response byte 2
    start_pkt(8'h01, 8'h44, 8'h99, 8'h01 ^ 8'h44 ^ 8'h99, 0);
    n = 0;
    while ((tx_wp - tx0) < 3 && n < 400) begin tick(); n++; end
    check("bp_first3", tx_wp - tx0, 3);
    txe_wrfull_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_wrreq_low", txe_wrreq_o, 0);
    end
    check("bp_held", tx_wp - tx0, 3);
    txe_wrfull_i = 1'b0;
    finish_pkt("bp", 1'b0);

    // Reset in the middle of a packet
    tx0 = tx_wp;
    push(8'hA5); push(8'h01); push(8'h10);
    n = 0;
    while (rx_rp != rx_wp && n < 50) begin tick(); n++; end
    repeat (4) tick();
    check("midrst_busy_before", busy_o, 1);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check_reset_outputs("midrst");
    exp_err = 0;
    start_pkt(8'h01, 8'h55, 8'hAA, 8'h01 ^ 8'h55 ^ 8'hAA, 0);
    finish_pkt("after_rst", 1'b0);

    for (int p = 0; p < 30; p++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)      c = 8'h01;
      else if (r < 8) c = 8'h02;
      else            c = 8'($urandom);
      a = 8'($urandom);
      d = 8'($urandom);
      k = c ^ a ^ d;
      if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
      start_pkt(c, a, d, k, int'($urandom_range(0, 2)));
      finish_pkt($sformatf("rand%0d", p), p[0]);
    end

    check("wrreq_while_full", full_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_cmd_parser.md
Name: usb_cmd_parser

Overview:
- Single-clock command decoder between the FT232H bridge FIFO ports and the scanner control-register bus.
- Pulls host bytes from the bridge RX FIFO read port.
- Frames fixed 5-byte command packets and performs one register write or read per packet.
- Pushes a fixed 5-byte response packet into the bridge TX FIFO write port.
- Runs on the same clock that drives the bridge's rxf_rdclk_i and txe_wrclk_i.

Parameters:
- RX_FIFO_L_BITS, 9, width of rxf_rdusedw_i; must match the bridge.
- TX_FIFO_L_BITS, 9, width of txe_wrusedw_i; TX depth = 2^TX_FIFO_L_BITS.
- TIMEOUT_CYCLES, 1000000, max idle cycles between bytes inside a partial packet.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- nrst  in  1  synchronous, active-low reset.
- rxf_rdreq_o  out  1  RX FIFO read request.
- rxf_rddata_i  in  8  RX FIFO data; valid the cycle after rxf_rdreq_o (non-showahead).
- rxf_rdusedw_i  in  RX_FIFO_L_BITS  RX FIFO byte count.
- txe_wrreq_o  out  1  TX FIFO write request.
- txe_wrdata_o  out  8  TX FIFO write data.
- txe_wrusedw_i  in  TX_FIFO_L_BITS  TX FIFO fill level.
- txe_wrfull_i  in  1  TX FIFO full.
- reg_wr_o  out  1  one-cycle register write strobe.
- reg_rd_o  out  1  one-cycle register read strobe.
- reg_addr_o  out  8  register address.
- reg_wdata_o  out  8  register write data.
- reg_rdata_i  in  8  register read data; valid the cycle after reg_rd_o.
- err_cnt_o  out  8  saturating protocol error count.
- busy_o  out  1  high whenever state is not S_SYNC.

Behaviour:
- Command packet: SYNC=0xA5, CMD, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA. CMD 0x01 = write, 0x02 = read; DATA is ignored for a read.
- Response packet: 0x5A, STATUS, ADDR, RDATA, RCHK, where RCHK = STATUS^ADDR^RDATA.
- STATUS codes: 0x00 OK, 0x01 bad checksum, 0x02 bad command.
- RDATA by outcome: write OK echoes DATA; read OK returns the captured reg_rdata_i; any error returns 0x00.
- Reset (nrst low at a clock edge), from any state including mid-packet or mid-response:
  - state goes to S_SYNC; all strobes go to 0.
  - reg_addr_o, reg_wdata_o, txe_wrdata_o and err_cnt_o go to 0.
  - any partial packet is discarded; no completing response is produced.
- Byte fetch, in states S_SYNC..S_CHK:
  - if rxf_rdusedw_i != 0 and no read is outstanding, assert rxf_rdreq_o for exactly one cycle.
  - capture rxf_rddata_i on the following cycle.
  - at most one byte every 2 cycles; never two back-to-back rdreq pulses.
- States and transitions:
  - S_SYNC: a byte equal to 0xA5 moves to S_CMD; any other byte is discarded silently and does not count as an error.
  - S_CMD, S_ADDR, S_DATA: latch the byte, then advance.
  - S_CHK: compare the byte against CHK, then go to S_EXEC.
  - S_EXEC, priority order: CHK mismatch gives STATUS 0x01 with no register access; otherwise a CMD not in {0x01, 0x02} gives STATUS 0x02; otherwise write pulses reg_wr_o one cycle and goes to S_RESP_WAIT, and read pulses reg_rd_o one cycle and goes to S_RDWAIT.
  - S_RDWAIT: capture reg_rdata_i (exactly 1 cycle after reg_rd_o), then go to S_RESP_WAIT.
  - S_RESP_WAIT: wait until txe_wrusedw_i <= 2^TX_FIFO_L_BITS - 6 and txe_wrfull_i == 0, then go to S_RESP.
  - S_RESP: byte index 0..4. Assert txe_wrreq_o with the indexed byte only on cycles with txe_wrfull_i == 0; otherwise hold wrreq low and keep the index. After index 4 is written, return to S_SYNC.
- reg_addr_o and reg_wdata_o update in S_EXEC and hold until the next S_EXEC.
- Timeout (S_CMD..S_CHK):
  - counter clears on every captured byte.
  - if it reaches TIMEOUT_CYCLES, go to S_SYNC, increment err_cnt_o, send no response.
  - no timeout applies in S_SYNC, S_RESP_WAIT or S_RESP.
- err_cnt_o increments by 1 per checksum error, bad command or timeout, and saturates at 0xFF.
- RX is not read during S_EXEC..S_RESP; host bytes accumulate in the bridge FIFO.

Test Plan:
- Write: RX bytes A5 01 10 3C 2D -> single reg_wr_o pulse with addr 0x10, wdata 0x3C; TX bytes 5A 00 10 3C 2C; err_cnt_o = 0.
- Read: RX bytes A5 02 20 00 22 with reg_rdata_i = 0x77 -> single reg_rd_o pulse with addr 0x20; no reg_wr_o; TX bytes 5A 00 20 77 57.
- Bad checksum / bad command:
  - A5 01 10 3C 00 -> no register strobes; TX 5A 01 10 00 11; err_cnt_o = 1.
  - A5 07 10 00 17 -> TX 5A 02 10 00 12; err_cnt_o = 2.
- Resync and timeout:
  - 00 FF 5A preceding a valid write -> leading bytes ignored; exactly one correct response; err_cnt_o unchanged.
  - A5 01 then idle TIMEOUT_CYCLES (set to 100 in the bench) -> busy_o low, err_cnt_o +1, no TX write.
- TX backpressure: txe_wrfull_i high for 20 cycles after byte 2 of the response -> txe_wrreq_o low throughout; bytes 3-4 follow afterwards with no loss or duplication. txe_wrusedw_i = depth-3 -> response is held in S_RESP_WAIT.
- Reset mid-packet: nrst low for 1 cycle after A5 01 10 -> all outputs return to reset values; the next full packet decodes correctly.
